// File: rtl/int_disp_queue.sv
// Integer dispatch queue: circular FIFO of renamed int uops feeding the int block, up to DEQ_NUM oldest per cycle.
// Latency: an entry written at edge t shows on o_disp_vld in cycle t+1; no bypass from empty.
// Backpressure: o_can_enq is a whole-group credit from the registered count; blocked enqueues are dropped.
module int_disp_queue #(
    parameter int DEPTH   = 16,
    parameter int ENQ_NUM = 4,
    parameter int DEQ_NUM = 4,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_squash_vld,
    input  logic [ENQ_NUM-1:0]         i_enq_vld,
    output logic                       o_can_enq,
    input  logic [ENQ_NUM*ENTRY_W-1:0] i_enq_data,
    output logic [DEQ_NUM-1:0]         o_disp_vld,
    output logic [DEQ_NUM*ENTRY_W-1:0] o_disp_data,
    input  logic [DEQ_NUM-1:0]         i_can_disp,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW-1:0]      count;
    logic [PW-1:0]      free_slots;
    logic [PW-1:0]      nenq;
    logic [PW-1:0]      ndeq;
    logic               enq_fire;
    logic [DEQ_NUM-1:0] deq_lanes;
    logic [ENTRY_W-1:0] mem [DEPTH];

    assign count      = tail - head;
    assign free_slots = PW'(DEPTH) - count;
    assign o_count    = count;
    assign o_empty    = (count == '0);
    assign o_full     = (count == PW'(DEPTH));
    // Credit only from the registered count, so dequeue never feeds back into it combinationally.
    assign o_can_enq  = (free_slots >= PW'(ENQ_NUM));

    // Enqueue lane count; a group is taken only with credit and no squash.
    always_comb begin
        nenq = '0;
        for (int k = 0; k < ENQ_NUM; k++) begin
            nenq = nenq + PW'(i_enq_vld[k]);
        end
        enq_fire = o_can_enq && !i_squash_vld && (i_enq_vld != '0);
    end

    // Dispatch lanes: the oldest min(count, DEQ_NUM) entries, hidden during squash.
    always_comb begin
        o_disp_vld  = '0;
        o_disp_data = '0;
        for (int k = 0; k < DEQ_NUM; k++) begin
            o_disp_vld[k] = (PW'(k) < count) && !i_squash_vld;
            o_disp_data[k*ENTRY_W +: ENTRY_W] = mem[head[AW-1:0] + AW'(k)];
        end
    end

    // Dequeue count from the lanes the int block actually accepted.
    always_comb begin
        deq_lanes = i_can_disp & o_disp_vld;
        ndeq      = '0;
        for (int k = 0; k < DEQ_NUM; k++) begin
            ndeq = ndeq + PW'(deq_lanes[k]);
        end
    end

    // Pointer update: reset, then squash, then normal enqueue/dequeue advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else if (i_squash_vld) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + ndeq;
            if (enq_fire) begin
                tail <= tail + nenq;
            end
        end
    end

    // Payload write: lane k lands in slot tail+k; storage itself is never cleared.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int k = 0; k < ENQ_NUM; k++) begin
                if (i_enq_vld[k]) begin
                    mem[tail[AW-1:0] + AW'(k)] <= i_enq_data[k*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

    // Protocol checks on the enqueue and dispatch handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((i_enq_vld & (i_enq_vld + 1'b1)) == '0)
                else $error("int_disp_queue: i_enq_vld is not a prefix");
            if (!o_can_enq) begin
                assert (i_enq_vld == '0)
                    else $warning("int_disp_queue: enqueue without credit dropped");
            end
            if (!i_squash_vld) begin
                assert ((i_can_disp & (i_can_disp + 1'b1)) == '0)
                    else $error("int_disp_queue: i_can_disp is not a prefix");
                assert ((i_can_disp & ~o_disp_vld) == '0)
                    else $error("int_disp_queue: i_can_disp exceeds o_disp_vld");
            end
        end
    end

endmodule

// File: tb/tb_int_disp_queue.sv
// Bench for int_disp_queue: directed scenarios then random traffic against a queue model.
// Latency: inputs change 1 time unit after posedge; outputs checked at negedge.
// Backpressure: the bench drives can_disp as a prefix within the model's valid lanes.
module tb_int_disp_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         squash;
    logic [3:0]   enq_vld;
    logic         can_enq;
    logic [255:0] enq_data;
    logic [3:0]   disp_vld;
    logic [255:0] disp_data;
    logic [3:0]   can_disp;
    logic [4:0]   count;
    logic         empty;
    logic         full;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [63:0]  q[$];
    int unsigned  seq = 0;
    logic         track = 1'b0;
    int unsigned  last_tag = 0;
    logic [63:0]  sav_a, sav_b, sav_c, sav_x;

    int_disp_queue #(.DEPTH(16), .ENQ_NUM(4), .DEQ_NUM(4), .ENTRY_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_squash_vld (squash),
        .i_enq_vld    (enq_vld),
        .o_can_enq    (can_enq),
        .i_enq_data   (enq_data),
        .o_disp_vld   (disp_vld),
        .o_disp_data  (disp_data),
        .i_can_disp   (can_disp),
        .o_count      (count),
        .o_empty      (empty),
        .o_full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pfx(input int n);
        return 4'((1 << n) - 1);
    endfunction

    function automatic int model_avail();
        if (squash) return 0;
        return (q.size() < 4) ? q.size() : 4;
    endfunction

    // Drive an enqueue group of n lanes with sequence-tagged payloads.
    task automatic set_enq(input int n);
        enq_vld = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                enq_vld[k] = 1'b1;
                enq_data[k*64 +: 64] = {8'hA5, 24'($urandom), seq};
                seq++;
            end else begin
                enq_data[k*64 +: 64] = {$urandom, $urandom};
            end
        end
    endtask

    // One clock: compare all outputs with the model, then advance the model.
    task automatic cycle();
        int cnt;
        int nv;
        int nd;
        @(negedge clk);
        cnt = q.size();
        nv  = model_avail();
        check("count",    64'(count),    64'(cnt));
        check("empty",    64'(empty),    64'(cnt == 0));
        check("full",     64'(full),     64'(cnt == 16));
        check("can_enq",  64'(can_enq),  64'((16 - cnt) >= 4));
        check("disp_vld", 64'(disp_vld), 64'(pfx(nv)));
        for (int k = 0; k < nv; k++) begin
            check($sformatf("lane%0d", k), disp_data[k*64 +: 64], q[k]);
        end
        if (rst || squash) begin
            q.delete();
        end else begin
            nd = 0;
            for (int k = 0; k < 4; k++) begin
                if (can_disp[k] && k < nv) nd++;
            end
            for (int k = 0; k < nd; k++) begin
                if (track) begin
                    check("tag_order", 64'(disp_data[k*64 +: 32]), 64'(last_tag + 1));
                    last_tag = disp_data[k*64 +: 32];
                end
                void'(q.pop_front());
            end
            if ((16 - cnt) >= 4) begin
                for (int k = 0; k < 4; k++) begin
                    if (enq_vld[k]) q.push_back(enq_data[k*64 +: 64]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; squash = 1'b0; can_disp = '0;
        set_enq(0);
    endtask

    task automatic reset_cycle();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_empty",    64'(empty),    64'd1);
        check("rst_can_enq",  64'(can_enq),  64'd1);
        check("rst_full",     64'(full),     64'd0);
        check("rst_disp_vld", 64'(disp_vld), 64'd0);
        check("rst_count",    64'(count),    64'd0);

        // Three-entry group, partial acceptance.
        set_enq(3);
        sav_a = enq_data[63:0]; sav_b = enq_data[127:64]; sav_c = enq_data[191:128];
        cycle();
        set_enq(0);
        can_disp = 4'b0011;
        #1;
        check("t2_vld",   64'(disp_vld), 64'h7);
        check("t2_a",     disp_data[63:0],    sav_a);
        check("t2_b",     disp_data[127:64],  sav_b);
        check("t2_c",     disp_data[191:128], sav_c);
        cycle();
        can_disp = 4'b0000;
        #1;
        check("t2_vld2",  64'(disp_vld), 64'h1);
        check("t2_lane0", disp_data[63:0], sav_c);
        check("t2_count", 64'(count), 64'd1);
        can_disp = 4'b0001;
        cycle();

        // Fill to full, then a blocked enqueue is dropped.
        reset_cycle();
        for (int g = 0; g < 4; g++) begin
            set_enq(4);
            cycle();
            if (g == 2) begin
                check("t3_count12",  64'(count),   64'd12);
                check("t3_can_enq1", 64'(can_enq), 64'd1);
            end
        end
        check("t3_count16", 64'(count),   64'd16);
        check("t3_full",    64'(full),    64'd1);
        check("t3_can_enq", 64'(can_enq), 64'd0);
        set_enq(4);
        cycle();
        set_enq(0);
        #1;
        check("t3_drop_count", 64'(count), 64'd16);

        // Drain to 12, then simultaneous enqueue and dequeue of four.
        can_disp = 4'b1111;
        cycle();
        sav_x = q[4];
        set_enq(4);
        cycle();
        set_enq(0);
        can_disp = '0;
        #1;
        check("t4_count", 64'(count), 64'd12);
        check("t4_lane0", disp_data[63:0], sav_x);

        // Streaming through several wraps with in-order tags.
        reset_cycle();
        last_tag = seq - 1;
        track = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_enq(4);
            can_disp = pfx(model_avail());
            cycle();
        end
        set_enq(0);
        for (int i = 0; i < 2; i++) begin
            can_disp = pfx(model_avail());
            cycle();
        end
        track = 1'b0;
        check("t5_last_tag", 64'(last_tag), 64'(seq - 1));

        // Squash with concurrent enqueue and dequeue.
        reset_cycle();
        set_enq(4); cycle();
        set_enq(3); cycle();
        set_enq(2);
        can_disp = 4'b1111;
        squash = 1'b1;
        #1;
        check("t6_vld_sq", 64'(disp_vld), 64'd0);
        cycle();
        idle_inputs();
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        cycle();
        check("t6_vld_after", 64'(disp_vld), 64'd0);

        // Random traffic with occasional squash and mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 63) == 0);
            squash = ($urandom_range(0, 15) == 0);
            if ((16 - q.size()) >= 4) set_enq($urandom_range(0, 4));
            else set_enq(0);
            can_disp = pfx($urandom_range(0, model_avail()));
            cycle();
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
